// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg
//   Shared constants for the write-back/commit stage: enable/disable levels,
//   zero word, load funct3 encodings and FSM state encodings.
//   No ports; imported by wb_commit and wb_commit_load_ext.
package wb_commit_pkg;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;

    localparam logic [0:0] WB_IDLE      = 1'b0;
    localparam logic [0:0] WB_LOAD_WAIT = 1'b1;

endpackage

// File: rtl/wb_commit_load_ext.sv
// wb_commit_load_ext
//   Combinational load-data extraction: selects the byte/halfword addressed by
//   the load offset from the raw aligned memory word and sign/zero-extends it.
// Ports
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   off     in  2   byte offset within the word
//   rdata   in  32  raw aligned memory word
//   data    out 32  extended result for the register file
module wb_commit_load_ext
    import wb_commit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Misaligned halfwords are not supported, so only off[1] picks the half.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            LB_F3:   data = {{24{byte_sel[7]}}, byte_sel};
            LH_F3:   data = {{16{half_sel[15]}}, half_sel};
            LBU_F3:  data = {24'h000000, byte_sel};
            LHU_F3:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// wb_commit
//   Write-back/commit stage driving the 32x32 register file write port.
//   Non-load instructions commit one cycle after acceptance; loads are parked
//   in LOAD_WAIT (stalling MEM) until the memory response arrives, then the
//   extended data is written. One registered write pulse per commit.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | accepting instructions from MEM
//   LOAD_WAIT | load latched, waiting for mem_done; MEM stalled
//
// Ports
//   dclk, rst          clock, synchronous active-high reset
//   rdy_CPU_i          global ready; low freezes all state
//   *_MEM_i            instruction / memory response from MEM
//   stall_MEM_o        MEM must hold its instruction (combinational)
//   *_REGFILE_o        registered register-file write port
//   retired_CPU_o      committed-instruction counter (wraps)
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             rdy_CPU_i,
    input  logic             valid_MEM_i,
    input  logic             we_MEM_i,
    input  logic [4:0]       waddr_MEM_i,
    input  logic [31:0]      wdata_MEM_i,
    input  logic             is_load_MEM_i,
    input  logic [2:0]       ld_funct3_MEM_i,
    input  logic [1:0]       ld_off_MEM_i,
    input  logic             mem_done_MEM_i,
    input  logic [31:0]      mem_rdata_MEM_i,
    output logic             stall_MEM_o,
    output logic             we_REGFILE_o,
    output logic [4:0]       waddr_REGFILE_o,
    output logic [31:0]      wdata_REGFILE_o,
    output logic [CNT_W-1:0] retired_CPU_o
);

    logic [0:0]  state;
    logic        ld_we;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [31:0] ld_data;

    wb_commit_load_ext u_load_ext (
        .funct3 (ld_funct3),
        .off    (ld_off),
        .rdata  (mem_rdata_MEM_i),
        .data   (ld_data)
    );

    assign stall_MEM_o = (state == WB_LOAD_WAIT);

    always_ff @(posedge dclk) begin
        if (rst) begin
            state           <= WB_IDLE;
            we_REGFILE_o    <= DISABLE;
            waddr_REGFILE_o <= 5'd0;
            wdata_REGFILE_o <= ZERO_WORD;
            retired_CPU_o   <= '0;
            ld_we           <= DISABLE;
            ld_rd           <= 5'd0;
            ld_funct3       <= 3'd0;
            ld_off          <= 2'd0;
        end else if (!rdy_CPU_i) begin
            // Frozen: hold everything but keep the write strobe a pulse.
            we_REGFILE_o <= DISABLE;
        end else begin
            we_REGFILE_o <= DISABLE;
            case (state)
                WB_IDLE: begin
                    if (valid_MEM_i && !is_load_MEM_i) begin
                        we_REGFILE_o    <= we_MEM_i && (waddr_MEM_i != 5'd0);
                        waddr_REGFILE_o <= waddr_MEM_i;
                        wdata_REGFILE_o <= wdata_MEM_i;
                        retired_CPU_o   <= retired_CPU_o + 1'b1;
                    end else if (valid_MEM_i) begin
                        ld_we     <= we_MEM_i;
                        ld_rd     <= waddr_MEM_i;
                        ld_funct3 <= ld_funct3_MEM_i;
                        ld_off    <= ld_off_MEM_i;
                        state     <= WB_LOAD_WAIT;
                    end
                end
                WB_LOAD_WAIT: begin
                    // MEM keeps presenting the load here; its fields are ignored.
                    if (mem_done_MEM_i) begin
                        we_REGFILE_o    <= ld_we && (ld_rd != 5'd0);
                        waddr_REGFILE_o <= ld_rd;
                        wdata_REGFILE_o <= ld_data;
                        retired_CPU_o   <= retired_CPU_o + 1'b1;
                        state           <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule
